uart_point_framer: RTL
======================

// Module: uart_point_framer
// PURPOSE
//  Sequences the uart_rx byte stream into 32-bit point words for the vector pipeline.
//  Packs 4 bytes LSB-first into a word, drops all-zero sync words (pulses o_Sync),
//  and resyncs on inter-byte timeout. Buffers words in a small FIFO with a valid/ready output.
//  Sits between uart_rx (o_Rx_DV/o_Rx_Byte) and the point consumer / DAC sequencer.
// PARAMETERS
//  TIMEOUT_CLKS  1024  idle clocks after a byte before a partial word is discarded (>=2)
//  FIFO_DEPTH    4     word buffer entries, power of two, >=2
// PORTS
//  i_Clock      in   1   system clock; single clock domain
//  i_Reset      in   1   synchronous, active-high reset
//  i_Rx_DV      in   1   one-cycle byte strobe from uart_rx
//  i_Rx_Byte    in   8   received byte, valid when i_Rx_DV=1
//  o_Valid      out  1   FIFO head holds a word
//  i_Ready      in   1   consumer accepts head when o_Valid & i_Ready
//  o_Word       out  32  FIFO head (first-word-fall-through); x=[11:0], y=[23:12], z/colour=[31:24]
//  o_Sync       out  1   one-cycle pulse when an all-zero word completes
//  o_Overflow   out  1   sticky: a word was dropped because the FIFO was full
//  o_Resync     out  1   one-cycle pulse when the timeout discards a partial word
// BEHAVIOUR
//  Reset: all outputs 0; byte index 0; timeout counter 0; FIFO empty; state S_COLLECT.
//   Reset mid-word discards partial bytes and FIFO contents.
//  Byte assembly: on i_Rx_DV, r_Asm[8*idx +: 8] <= i_Rx_Byte; idx <= idx+1 (2-bit, wraps 3->0).
//   On the idx==3 byte, go to S_COMMIT for exactly one cycle with r_Asm complete.
//  States: S_COLLECT -(DV & idx==3)-> S_COMMIT -> S_COLLECT.
//  S_COMMIT: word==0 -> o_Sync=1, no push. Else push; if FIFO full and no pop this cycle,
//   drop word, set o_Overflow. Full & simultaneous pop -> push accepted.
//  Latency: 4th-byte DV at cycle N -> word in FIFO, o_Valid=1 at N+2 (FIFO was empty).
//  A DV arriving in S_COMMIT is accepted as byte 0 of the next word; no byte is lost.
//  Timeout: counter clears on every DV; increments only while idx!=0 and no DV.
//   Saturates when it reaches TIMEOUT_CLKS-1 -> idx<=0, o_Resync pulses 1 cycle, counter clears.
//   If DV and expiry coincide, DV wins: byte stored, counter cleared, no resync.
//   idx==0 never times out.
//  FIFO: pop when o_Valid & i_Ready; push+pop same cycle keeps count; pop on empty ignored.
//   o_Word is stable while o_Valid & !i_Ready.
//  Widths: counter $clog2(TIMEOUT_CLKS) bits; FIFO count $clog2(FIFO_DEPTH)+1 bits.
//   Pointers wrap naturally.
// STRUCTURE
//  Header vector_defs.vh: point field offsets/widths (X_LSB, Y_LSB, Z_LSB, COORD_W),
//   word width 32, and state encodings S_COLLECT/S_COMMIT.
//  One sub-module: point_fifo (sync FWFT FIFO, DEPTH/WIDTH params, push/pop/full/empty/head).
//  Top holds assembler, state machine, timeout counter, and flag logic.
// TESTING
//  1. Bytes 01 02 03 04 -> o_Word=32'h04030201, o_Valid 2 cycles after 4th DV; i_Ready=1 pops it; FIFO empty.
//  2. Bytes 00 x8, then 01 02 03 04, 02 04 06 08, 01 01 01 01 -> two o_Sync pulses, no pushes;
//     then words 04030201, 08060402, 01010101 in order.
//  3. Bytes AA BB, then idle TIMEOUT_CLKS clocks, then 01 02 03 04 -> one o_Resync pulse;
//     only 04030201 emitted.
//  4. i_Ready=0, send 5 nonzero words (FIFO_DEPTH=4) -> first 4 held, 5th dropped, o_Overflow=1 until reset.
//  5. FIFO full, i_Ready=1 in the commit cycle -> push accepted, count stays 4, o_Overflow stays 0.
//  6. i_Reset asserted after 2 bytes and with 2 words buffered -> next cycle o_Valid=0, flags 0;
//     next 4 bytes form a clean word.

Source files
------------

// File: rtl/uart_point_framer_pkg.sv
// Shared definitions for the UART point framer: point word layout,
// framer state encoding and a small helper to recognise sync words.
package uart_point_framer_pkg;

  localparam int WORD_W  = 32;
  localparam int BYTE_W  = 8;
  localparam int COORD_W = 12;
  localparam int X_LSB   = 0;
  localparam int Y_LSB   = 12;
  localparam int Z_LSB   = 24;
  localparam int Z_W     = 8;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_COMMIT  = 1'b1
  } framer_state_e;

  // An all-zero word is a stream sync marker, never a real point.
  function automatic logic isSyncWord(input logic [WORD_W-1:0] w);
    return (w == '0);
  endfunction

endpackage

// File: rtl/uart_point_framer_fifo.sv
// Synchronous first-word-fall-through FIFO holding assembled point words.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module point_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i & (~full_o | pop_i);
  assign doPop   = pop_i & ~empty_o;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (!doPush && doPop) count_d = count_q - 1'b1;
  end

  // Control registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_point_framer.sv
// Packs the uart_rx byte stream LSB-first into 32-bit point words, drops
// all-zero sync words, discards stale partial words after an idle timeout,
// and buffers finished words in a FWFT FIFO with a valid/ready interface.
module uart_point_framer
  import uart_point_framer_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1024,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [BYTE_W-1:0] i_Rx_Byte,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [WORD_W-1:0] o_Word,
  output logic              o_Sync,
  output logic              o_Overflow,
  output logic              o_Resync
);

  localparam int              CNT_W      = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  framer_state_e     state_q, state_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [WORD_W-1:0] asmWord_q, asmWord_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic              overflow_q, overflow_d;
  logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [WORD_W-1:0] fifoHead;

  assign fifoPop    = ~fifoEmpty & i_Ready;
  assign o_Valid    = ~fifoEmpty;
  assign o_Word     = fifoHead;
  assign o_Overflow = overflow_q;

  // Byte assembly, idle timeout and commit decision. A byte arriving during
  // the commit cycle lands in slot 0 while the completed word is pushed.
  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    asmWord_d  = asmWord_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    fifoPush   = 1'b0;
    o_Sync     = 1'b0;
    o_Resync   = 1'b0;

    if (i_Rx_DV) begin
      asmWord_d[{byteIdx_q, 3'b000} +: BYTE_W] = i_Rx_Byte;
      byteIdx_d = byteIdx_q + 2'd1;
      timer_d   = '0;
    end else if (byteIdx_q != 2'd0) begin
      if (timer_q == TIMER_LAST) begin
        byteIdx_d = 2'd0;
        timer_d   = '0;
        o_Resync  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    case (state_q)
      S_COLLECT: begin
        if (i_Rx_DV && byteIdx_q == 2'd3) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_COLLECT;
        if (isSyncWord(asmWord_q))        o_Sync     = 1'b1;
        else if (fifoFull && !fifoPop)    overflow_d = 1'b1;
        else                              fifoPush   = 1'b1;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Framer state registers with synchronous reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_COLLECT;
      byteIdx_q  <= 2'd0;
      asmWord_q  <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteIdx_q  <= byteIdx_d;
      asmWord_q  <= asmWord_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  point_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) uFifo (
    .clk_i   (i_Clock),
    .reset_i (i_Reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .data_i  (asmWord_q),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (fifoHead)
  );

endmodule
